// File: rtl/bip_pkg.sv
// bip_pkg: opcode, accumulator-mux and FSM state encodings shared by the sequencer and decoder
package bip_pkg;
    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [1:0] SEL_RAM = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_ALU = 2'd2;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
`ifdef SINGLE_STEP_EN
    localparam logic [2:0] ST_PAUSE  = 3'd5;
`endif
    localparam logic [2:0] ST_HALT   = 3'd6;
    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       wr_ram;
    } ctrl_t;
    function automatic logic needs_mem(input logic [4:0] opc);
        return opc == OP_LD || opc == OP_ADD || opc == OP_SUB;
    endfunction
endpackage

// File: rtl/bip_sequencer_if.sv
// bip_sequencer_if: sequencer control bus; step_mode/step/paused exist only with SINGLE_STEP_EN
interface bip_sequencer_if;
    logic        start;
    logic [15:0] instr;
    logic        rom_en;
    logic        wr_pc;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op;
    logic        wr_acc;
    logic        wr_ram;
    logic        rd_ram;
    logic [10:0] operand;
    logic        halted;
    logic [15:0] cycle_cnt;
`ifdef SINGLE_STEP_EN
    logic        step_mode;
    logic        step;
    logic        paused;
`endif
    modport slave (
        input  start, instr,
        output rom_en, wr_pc, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, operand, halted, cycle_cnt
`ifdef SINGLE_STEP_EN
        , input step_mode, step, output paused
`endif
    );
    modport master (
        output start, instr,
        input  rom_en, wr_pc, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, operand, halted, cycle_cnt
`ifdef SINGLE_STEP_EN
        , output step_mode, step, input paused
`endif
    );
endinterface

// File: rtl/ins_deco.sv
// ins_deco: maps a latched opcode to its EXEC-cycle datapath controls; unknown opcodes decode to all-zero (NOP)
module ins_deco
    import bip_pkg::*;
(
    input  logic [4:0] opcode_i,
    output ctrl_t      ctrl_o
);
    logic alu;
    assign alu = opcode_i inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI};
    always_comb begin
        ctrl_o        = '0;
        ctrl_o.sel_a  = opcode_i == OP_LDI ? SEL_IMM : alu ? SEL_ALU : SEL_RAM;
        ctrl_o.sel_b  = opcode_i inside {OP_ADDI, OP_SUBI};
        ctrl_o.op     = opcode_i inside {OP_SUB, OP_SUBI};
        ctrl_o.wr_acc = alu || opcode_i inside {OP_LD, OP_LDI};
        ctrl_o.wr_ram = opcode_i == OP_STO;
    end
endmodule

// File: rtl/sat_counter.sv
// sat_counter: up-counter with enable and synchronous clear that sticks at all-ones
module sat_counter #(parameter int WIDTH = 16) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (en_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= clr_i ? '0 : cnt_d;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/bip_sequencer.sv
// bip_sequencer: BIP fetch/decode/mem/exec control FSM; define SINGLE_STEP_EN for step_mode/step/paused and PAUSE
module bip_sequencer
    import bip_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    bip_sequencer_if.slave bus
);
    logic [2:0]  state_q, state_d;
    logic [4:0]  opcode_q, opcode_d;
    logic [10:0] operand_q, operand_d;
    logic        in_exec;
    ctrl_t       ctrl;

    ins_deco u_deco (.opcode_i(opcode_q), .ctrl_o(ctrl));

    sat_counter #(.WIDTH(16)) u_cnt (
        .clk   (clk),
        .clr_i (reset),
        .en_i  (state_q inside {ST_FETCH, ST_DECODE, ST_MEM, ST_EXEC}),
        .cnt_o (bus.cycle_cnt)
    );

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        case (state_q)
            ST_IDLE:   state_d = bus.start ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                opcode_d  = bus.instr[15:11];
                operand_d = bus.instr[10:0];
                state_d   = bus.instr[15:11] == OP_HLT ? ST_HALT :
                            needs_mem(bus.instr[15:11]) ? ST_MEM : ST_EXEC;
            end
            ST_MEM:    state_d = ST_EXEC;
`ifdef SINGLE_STEP_EN
            ST_EXEC:   state_d = bus.step_mode ? ST_PAUSE : ST_FETCH;
            ST_PAUSE:  state_d = (bus.step || !bus.step_mode) ? ST_FETCH : ST_PAUSE;
`else
            ST_EXEC:   state_d = ST_FETCH;
`endif
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
        end
    end

    // datapath controls are gated so they read zero outside EXEC
    assign in_exec    = state_q == ST_EXEC;
    assign bus.rom_en = state_q == ST_FETCH;
    assign bus.rd_ram = state_q == ST_MEM;
    assign bus.wr_pc  = in_exec;
    assign bus.wr_acc = in_exec & ctrl.wr_acc;
    assign bus.wr_ram = in_exec & ctrl.wr_ram;
    assign bus.sel_a  = in_exec ? ctrl.sel_a : SEL_RAM;
    assign bus.sel_b  = in_exec & ctrl.sel_b;
    assign bus.op     = in_exec & ctrl.op;
    assign bus.operand = operand_q;
    assign bus.halted = state_q == ST_HALT;
`ifdef SINGLE_STEP_EN
    assign bus.paused = state_q == ST_PAUSE;
`endif
endmodule

// File: doc/bip_sequencer.md
BIP_SEQUENCER -- requirements
Module: bip_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  one-cycle pulse, begins execution from IDLE.
REQ-004 SHALL have ports: instr  in  16  ROM read data, valid the cycle after rom_en.
REQ-005 SHALL have ports: rom_en  out  1  instruction ROM read strobe at current pc.
REQ-006 SHALL have ports: wr_pc  out  1  pc increment enable.
REQ-007 SHALL have ports: sel_a  out  2  acc mux: 0 RAM data, 1 immediate, 2 ALU.
REQ-008 SHALL have ports: sel_b  out  1  ALU operand B: 0 RAM data, 1 immediate.
REQ-009 SHALL have ports: op  out  1  ALU op: 0 add, 1 sub.
REQ-010 SHALL have ports: wr_acc, wr_ram, rd_ram  out  1 each  datapath/RAM strobes.
REQ-011 SHALL have ports: operand  out  11  registered instr[10:0].
REQ-012 SHALL have ports: halted  out  1  high in HALT; cycle_cnt  out  16  execution cycle count.
REQ-013 SHALL have, under SINGLE_STEP_EN only: step_mode  in  1; step  in  1; paused  out  1.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DECODE, MEM, EXEC, PAUSE, HALT.
REQ-015 IDLE: all strobes low; start=1 -> FETCH next cycle; start ignored in every other state.
REQ-016 FETCH: rom_en=1 exactly one cycle -> DECODE.
REQ-017 DECODE: latch opcode=instr[15:11], operand=instr[10:0]; opcode 00000 (HLT) -> HALT; 00010/00100/00110 (LD/ADD/SUB) -> MEM; all others -> EXEC.
REQ-018 MEM: rd_ram=1 one cycle, RAM address = operand; -> EXEC (1-cycle synchronous RAM latency).
REQ-019 EXEC: wr_pc=1 one cycle plus per-opcode strobes: STO 00001 wr_ram=1; LD sel_a=0 wr_acc=1; LDI 00011 sel_a=1 wr_acc=1; ADD sel_a=2 sel_b=0 op=0 wr_acc=1; ADDI 00101 sel_a=2 sel_b=1 op=0 wr_acc=1; SUB sel_a=2 sel_b=0 op=1 wr_acc=1; SUBI 00111 sel_a=2 sel_b=1 op=1 wr_acc=1.
REQ-020 Opcodes 01000-11111 SHALL execute as NOP: only wr_pc=1 in EXEC.
REQ-021 EXEC -> FETCH (or PAUSE per REQ-028); instruction latency: 3 cycles immediate/STO, 4 cycles LD/ADD/SUB.
REQ-022 Outside their state, rom_en, rd_ram, wr_ram, wr_acc, wr_pc SHALL be 0; sel_a, sel_b, op SHALL be 0.
REQ-023 HALT: halted=1, all strobes 0, held until reset; wr_pc never asserted for HLT.
REQ-024 cycle_cnt SHALL increment each cycle the FSM is outside IDLE/HALT/PAUSE, saturate at 16'hFFFF, hold in HALT.

Reset
REQ-025 reset SHALL force IDLE, operand=0, opcode=0, cycle_cnt=0, halted=0, paused=0, all strobes 0 on the next edge, from any state including mid-instruction; reset has priority over start/step.

Configuration
REQ-026 Macro SINGLE_STEP_EN SHALL compile in step_mode, step, paused and the PAUSE state.
REQ-027 Without SINGLE_STEP_EN: EXEC always -> FETCH; ports and PAUSE absent.
REQ-028 With SINGLE_STEP_EN: step_mode=1 sampled in EXEC -> PAUSE; PAUSE holds paused=1, strobes 0; step=1 -> FETCH; step_mode=0 in PAUSE -> FETCH; step outside PAUSE ignored.

Structure
REQ-029 Opcode constants, sel_a encodings and state encodings SHALL live in shared package bip_pkg (include file), reused by ins_deco.
REQ-030 cycle_cnt SHALL be a sub-module sat_counter (width 16, enable, synchronous clear).

Verification
REQ-031 reset, start, instr=16'h1805 (LDI 5) -> rom_en cycle 1, wr_acc=1 sel_a=1 operand=5 wr_pc=1 cycle 3.
REQ-032 instr=16'h2003 (ADD 3) -> rd_ram=1 operand=3 cycle 3, wr_acc=1 sel_a=2 sel_b=0 op=0 cycle 4.
REQ-033 instr=16'h0000 -> halted=1 from cycle 3, no wr_pc, cycle_cnt frozen at 2; later start ignored.
REQ-034 instr=16'hF800 -> only wr_pc=1 in EXEC; reset asserted during MEM -> IDLE, cycle_cnt=0 next cycle.
REQ-035 SINGLE_STEP_EN, step_mode=1, SUBI 1 -> paused=1 after EXEC; step pulse -> rom_en next cycle.
REQ-036 Force cycle_cnt to 16'hFFFE, run 3 cycles -> reads 16'hFFFF, no wrap.
